// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after last_grant, with wrap-around.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            valid
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        // Offset NREQ lands on last_grant itself, so a lone requester can win again.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!valid && eligible[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB bus between NREQ requesters.
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      grant,
    output logic [AW-1:0]        PADDR,
    output logic [DW-1:0]        PWDATA,
    output logic                 PWRITE,
    output logic                 PSELx,
    output logic                 PENABLE,
    input  logic                 PREADY,
    input  logic [DW-1:0]        PRDATA
);

    localparam int IW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic [AW-1:0]     paddr_q, paddr_d;
    logic [DW-1:0]     pwdata_q, pwdata_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;

    logic [AW-1:0]     addr_arr  [NREQ];
    logic [DW-1:0]     wdata_arr [NREQ];
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   win_onehot;
    logic [IW-1:0]     win_idx;
    logic              win_valid;
    logic              timed_out;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*AW +: AW];
            assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
        end
    endgenerate

    // A requester in its done cycle still shows req high; keep it out of this round.
    assign eligible = req & ~done_q;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant_q),
        .grant      (win_onehot),
        .grant_idx  (win_idx),
        .valid      (win_valid)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // cnt_q holds the number of PREADY-low ACCESS cycles already elapsed.
    assign timed_out = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign err       = err_q;

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        case (state_q)
            SETUP:   cnt_d = '0;
            ACCESS: begin
                if (PREADY || timed_out) err_d = timed_out;
                else                     cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        rdata_d      = rdata_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    paddr_d   = addr_arr[win_idx];
                    pwdata_d  = wdata_arr[win_idx];
                    pwrite_d  = req_write[win_idx];
                    grant_d   = win_onehot;
                    gidx_d    = win_idx;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY || timed_out) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    grant_d      = '0;
                    done_d       = grant_q;
                    last_grant_d = gidx_q;
                    state_d      = IDLE;
                    if (PREADY && !pwrite_q) rdata_d = PRDATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(NREQ - 1);
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            rdata_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            rdata_q      <= rdata_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
        end
    end

    assign done    = done_q;
    assign rdata   = rdata_q;
    assign grant   = grant_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PSELx   = psel_q;
    assign PENABLE = penable_q;

endmodule
